// File: rtl/sonar_scan_sequencer.sv
// Round-robin ultrasonic scan sequencer sharing one pwm_measure block.
// Triggers each sensor in turn, times out silent ones, latches distances.
module sonar_scan_sequencer #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int SETTLE_CYCLES  = 2,
  parameter int GAP_CYCLES     = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_SENSORS-1:0]     echo_in,
  output logic [N_SENSORS-1:0]     trig_out,
  output logic                     meas_pwm,
  output logic                     meas_reset,
  input  logic [7:0]               meas_distance,
  output logic [8*N_SENSORS-1:0]   dist_out,
  output logic [N_SENSORS-1:0]     dist_valid,
  output logic [N_SENSORS-1:0]     timeout_flag,
  output logic [$clog2(N_SENSORS)-1:0] cur_sel,
  output logic                     scan_done
);

  localparam int SW = $clog2(N_SENSORS);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SET_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, TRIG, WAIT_RISE, WAIT_FALL, SETTLE, GAP
  } state_t;

  state_t state;
  logic [N_SENSORS-1:0] sync1, sync2, sync3;
  logic [31:0] cnt;
  logic echo_sel, echo_prev, rise, fall;

  assign echo_sel  = sync2[cur_sel];
  assign echo_prev = sync3[cur_sel];
  assign rise      = echo_sel & ~echo_prev;
  assign fall      = ~echo_sel & echo_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= echo_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur_sel      <= '0;
      cnt          <= '0;
      trig_out     <= '0;
      meas_pwm     <= 1'b0;
      meas_reset   <= 1'b0;
      scan_done    <= 1'b0;
      dist_out     <= '0;
      dist_valid   <= '0;
      timeout_flag <= '0;
    end else begin
      scan_done  <= 1'b0;
      meas_reset <= 1'b0;
      meas_pwm   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            cur_sel    <= '0;
            cnt        <= '0;
            meas_reset <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          trig_out[cur_sel] <= 1'b1;
          cnt               <= '0;
          state             <= TRIG;
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            trig_out <= '0;
            cnt      <= '0;
            state    <= WAIT_RISE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_RISE, WAIT_FALL: begin
          meas_pwm <= echo_sel;
          // edges take priority over an expiring timeout
          if (state == WAIT_RISE && rise) begin
            cnt   <= cnt + 32'd1;
            state <= WAIT_FALL;
          end else if (state == WAIT_FALL && fall) begin
            cnt   <= '0;
            state <= SETTLE;
          end else if (cnt >= TO_LAST) begin
            dist_out[int'(cur_sel)*8 +: 8] <= 8'hFF;
            dist_valid[cur_sel]   <= 1'b0;
            timeout_flag[cur_sel] <= 1'b1;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SETTLE: begin
          meas_pwm <= echo_sel;
          if (cnt == SET_LAST) begin
            dist_out[int'(cur_sel)*8 +: 8] <= meas_distance;
            dist_valid[cur_sel]   <= 1'b1;
            timeout_flag[cur_sel] <= 1'b0;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (cur_sel != SEL_LAST) begin
              cur_sel    <= cur_sel + 1'b1;
              meas_reset <= 1'b1;
              state      <= CLEAR;
            end else begin
              scan_done <= 1'b1;
              cur_sel   <= '0;
              if (enable) begin
                meas_reset <= 1'b1;
                state      <= CLEAR;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Directed bench for sonar_scan_sequencer with a behavioural pwm_measure.
// Sensor echoes are launched relative to the observed end of each trigger.
module tb_sonar_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [1:0] echo_in;
  logic [1:0] trig_out;
  logic meas_pwm, meas_reset;
  logic [7:0] meas_distance;
  logic [15:0] dist_out;
  logic [1:0] dist_valid, timeout_flag;
  logic [0:0] cur_sel;
  logic scan_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonar_scan_sequencer #(
    .N_SENSORS(2), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(200),
    .SETTLE_CYCLES(2), .GAP_CYCLES(3)
  ) dut (
    .clk(clk), .reset(rst), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .meas_pwm(meas_pwm), .meas_reset(meas_reset),
    .meas_distance(meas_distance), .dist_out(dist_out),
    .dist_valid(dist_valid), .timeout_flag(timeout_flag),
    .cur_sel(cur_sel), .scan_done(scan_done)
  );

  // pwm_measure stand-in: counts high cycles since the last clear
  logic [7:0] mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 8'd0;
    else if (meas_reset) mcnt <= 8'd0;
    else if (meas_pwm && mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
  end
  assign meas_distance = mcnt;

  typedef struct {
    int d0; int h0; int d1; int h1;
    logic [7:0] e0; logic [7:0] e1;
    logic [1:0] ev; logic [1:0] et;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // wait for trig on sensor idx, measure its width, then drive an echo
  // d cycles after trigger end, h cycles wide (h=0: sensor stays silent)
  task automatic serve(input int idx, input int d, input int h);
    int n;
    int len;
    n = 0;
    while (!trig_out[idx] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!trig_out[idx]) begin
      chk("trig_wait", 32'(trig_out[idx]), 32'd1);
      return;
    end
    len = 0;
    while (trig_out[idx] && len < 100) begin
      @(negedge clk);
      len++;
    end
    chk("trig_len", len, 32'd4);
    if (h > 0) begin
      repeat (d) @(negedge clk);
      echo_in[idx] = 1'b1;
      repeat (h) @(negedge clk);
      echo_in[idx] = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!scan_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("scan_done_seen", 32'(scan_done), 32'd1);
    @(negedge clk);
    chk("scan_done_pulse", 32'(scan_done), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    echo_in = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int bad;
    do_reset();
    enable = 1'b1;
    serve(0, vecs[k].d0, vecs[k].h0);
    enable = 1'b0;
    serve(1, vecs[k].d1, vecs[k].h1);
    wait_done();
    chk($sformatf("v%0d_slot0", k), 32'(dist_out[7:0]), 32'(vecs[k].e0));
    chk($sformatf("v%0d_slot1", k), 32'(dist_out[15:8]), 32'(vecs[k].e1));
    chk($sformatf("v%0d_valid", k), 32'(dist_valid), 32'(vecs[k].ev));
    chk($sformatf("v%0d_tflag", k), 32'(timeout_flag), 32'(vecs[k].et));
    chk($sformatf("v%0d_sel", k), 32'(cur_sel), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trig_out != 2'b00) bad++;
    end
    chk($sformatf("v%0d_idle_trig", k), bad, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    bit ms;

    vecs[0] = '{d0:3,   h0:25, d1:3, h1:25, e0:8'd25, e1:8'd25,
                ev:2'b11, et:2'b00};
    vecs[1] = '{d0:3,   h0:25, d1:0, h1:0,  e0:8'd25, e1:8'hFF,
                ev:2'b01, et:2'b10};
    vecs[2] = '{d0:172, h0:25, d1:3, h1:10, e0:8'd25, e1:8'd10,
                ev:2'b11, et:2'b00};
    vecs[3] = '{d0:173, h0:25, d1:3, h1:25, e0:8'hFF, e1:8'd25,
                ev:2'b10, et:2'b01};
    vecs[4] = '{d0:5,   h0:7,  d1:1, h1:40, e0:8'd7,  e1:8'd40,
                ev:2'b11, et:2'b00};
    vecs[5] = '{d0:0,   h0:0,  d1:0, h1:0,  e0:8'hFF, e1:8'hFF,
                ev:2'b00, et:2'b11};

    rst = 1'b1;
    enable = 1'b0;
    echo_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(trig_out), 32'd0);
    chk("rst_dist", 32'(dist_out), 32'd0);
    chk("rst_valid", 32'(dist_valid), 32'd0);
    chk("rst_tflag", 32'(timeout_flag), 32'd0);
    chk("rst_ctrl", {29'd0, meas_pwm, meas_reset, scan_done}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_trig", 32'(trig_out), 32'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // crosstalk on sensor 1 while sensor 0 times out
    do_reset();
    enable = 1'b1;
    serve(0, 0, 0);
    enable = 1'b0;
    n = 0;
    bad = 0;
    while (!timeout_flag[0] && n < 400) begin
      @(negedge clk);
      n++;
      echo_in[1] = (n < 150) ? 1'((n / 7) % 2) : 1'b0;
      if (meas_pwm) bad++;
    end
    chk("timeout_len", n, 32'd200);
    chk("xtalk_pwm", bad, 32'd0);
    chk("xtalk_slot1", 32'(dist_out[15:8]), 32'd0);
    chk("xtalk_valid1", 32'(dist_valid[1]), 32'd0);
    chk("to_slot0", 32'(dist_out[7:0]), 32'hFF);
    serve(1, 3, 12);
    wait_done();
    chk("xtalk_slot1_own", 32'(dist_out[15:8]), 32'd12);
    chk("xtalk_valid", 32'(dist_valid), 32'd2);
    chk("xtalk_tflag", 32'(timeout_flag), 32'd1);

    // reset in the middle of a trigger pulse
    enable = 1'b1;
    n = 0;
    while (!trig_out[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_trig_seen", 32'(trig_out), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_trig", 32'(trig_out), 32'd0);
    chk("mid_rst_dist", 32'(dist_out), 32'd0);
    chk("mid_rst_flags", {28'd0, dist_valid, timeout_flag}, 32'd0);
    chk("mid_rst_sel", 32'(cur_sel), 32'd0);
    chk("mid_rst_ctrl", {29'd0, meas_pwm, meas_reset, scan_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    ms = 1'b0;
    while (trig_out == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
      if (meas_reset) ms = 1'b1;
    end
    chk("restart_lat", n, 32'd2);
    chk("restart_sensor", 32'(trig_out), 32'd1);
    chk("restart_clear", 32'(ms), 32'd1);

    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
